buf_addr_mgmt: RTL and testbench

Buffer address manager for the 2048×134-bit packet cache. Hands out fixed-size buffer base addresses to the ingress path and to the packet RAM write side via `addr2data_waddr*`. Queues completed packets in arrival order and issues read base addresses via `addr2data_raddr*` when the egress side is ready. Recycles each buffer once its tail word has been read out.

---
 rtl/buf_addr_mgmt.sv | 171 +++++++++++++++++
 tb/tb_buf_addr_mgmt.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_addr_mgmt.sv
`timescale 1ns/1ps
// Buffer address manager for the packet cache: grants buffer base addresses to
// ingress, queues finished packets in arrival order and recycles buffers after readout.
//
// state  | meaning
// W_IDLE | no buffer held by ingress; grant on request when a buffer is free
// W_BUSY | ingress is filling the granted buffer; tail word queues it for read
// R_IDLE | waiting for a queued packet and in_ebm_ready
// R_WAIT | read of the issued buffer in progress; tail-out releases it
// R_GAP  | two idle cycles so the RAM read side can settle
module buf_addr_mgmt #(
    parameter int BUF_NUM   = 16,
    parameter int BUF_SHIFT = 7,
    parameter int ADDR_W    = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_pkt_req,
    input  logic [133:0]              in_data_ctrl_data,
    input  logic                      in_data_ctrl_data_wr,
    input  logic                      in_ebm_ready,
    input  logic                      out_data_cache_valid_wr,
    output logic [ADDR_W-1:0]         addr2data_waddr,
    output logic                      addr2data_waddr_wr,
    output logic [ADDR_W-1:0]         addr2data_raddr,
    output logic                      addr2data_raddr_wr,
    output logic [$clog2(BUF_NUM):0]  out_free_cnt,
    output logic [$clog2(BUF_NUM):0]  out_txq_cnt,
    output logic                      out_wr_err
);

    localparam int ID_W  = $clog2(BUF_NUM);
    localparam int CNT_W = ID_W + 1;
    localparam int WC_W  = BUF_SHIFT + 1;
    localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(2 ** BUF_SHIFT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_NUM);
    localparam logic [1:0]       GAP_LOAD = 2'd1;

    typedef enum logic {W_IDLE, W_BUSY} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_GAP} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [ID_W-1:0]  free_mem [BUF_NUM];
    logic [ID_W-1:0]  txq_mem  [BUF_NUM];
    logic [ID_W-1:0]  free_rd_ptr, free_wr_ptr, txq_rd_ptr, txq_wr_ptr;
    logic [CNT_W-1:0] free_cnt, txq_cnt;
    logic [ID_W-1:0]  cur_wid, cur_rid;
    logic [WC_W-1:0]  word_cnt;
    logic [1:0]       gap_cnt;

    logic tail_word, grant, wr_done, rd_start, rel_buf, err_nxt;
    logic unused_data;

    assign unused_data = ^in_data_ctrl_data[131:0];
    assign tail_word   = in_data_ctrl_data_wr && (in_data_ctrl_data[133:132] == 2'b10);

    function automatic logic [ADDR_W-1:0] base_addr(input logic [ID_W-1:0] id);
        return ADDR_W'(id) << BUF_SHIFT;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE: if (in_pkt_req && free_cnt != '0) w_state_nxt = W_BUSY;
            W_BUSY: if (tail_word) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE: if (in_ebm_ready && txq_cnt != '0) r_state_nxt = R_WAIT;
            R_WAIT: if (out_data_cache_valid_wr) r_state_nxt = R_GAP;
            R_GAP:  if (gap_cnt == '0) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        grant    = (w_state == W_IDLE) && in_pkt_req && (free_cnt != '0);
        wr_done  = (w_state == W_BUSY) && tail_word;
        rd_start = (r_state == R_IDLE) && in_ebm_ready && (txq_cnt != '0);
        rel_buf  = (r_state == R_WAIT) && out_data_cache_valid_wr;
        // A word arriving in the same edge as the grant is dropped silently.
        err_nxt  = ((w_state == W_IDLE) && in_data_ctrl_data_wr && !grant) ||
                   ((w_state == W_BUSY) && in_data_ctrl_data_wr && (word_cnt == WC_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_NUM; i++) free_mem[i] <= ID_W'(i);
            free_rd_ptr        <= '0;
            free_wr_ptr        <= '0;
            free_cnt           <= CNT_FULL;
            txq_rd_ptr         <= '0;
            txq_wr_ptr         <= '0;
            txq_cnt            <= '0;
            cur_wid            <= '0;
            cur_rid            <= '0;
            word_cnt           <= '0;
            gap_cnt            <= '0;
            addr2data_waddr    <= '0;
            addr2data_waddr_wr <= 1'b0;
            addr2data_raddr    <= '0;
            addr2data_raddr_wr <= 1'b0;
            out_wr_err         <= 1'b0;
        end else begin
            addr2data_waddr_wr <= grant;
            addr2data_raddr_wr <= rd_start;
            out_wr_err         <= err_nxt;

            if (grant) begin
                addr2data_waddr <= base_addr(free_mem[free_rd_ptr]);
                cur_wid         <= free_mem[free_rd_ptr];
                free_rd_ptr     <= free_rd_ptr + ID_W'(1);
                word_cnt        <= '0;
            end else if (w_state == W_BUSY && in_data_ctrl_data_wr && word_cnt <= WC_MAX) begin
                // Saturates one past the buffer size so an overrun flags only once.
                word_cnt <= word_cnt + WC_W'(1);
            end

            if (rel_buf) begin
                free_mem[free_wr_ptr] <= cur_rid;
                free_wr_ptr           <= free_wr_ptr + ID_W'(1);
            end

            case ({rel_buf, grant})
                2'b10:   free_cnt <= free_cnt + CNT_W'(1);
                2'b01:   free_cnt <= free_cnt - CNT_W'(1);
                default: free_cnt <= free_cnt;
            endcase

            if (wr_done) txq_wr_ptr <= txq_wr_ptr + ID_W'(1);

            if (rd_start) begin
                addr2data_raddr <= base_addr(txq_mem[txq_rd_ptr]);
                cur_rid         <= txq_mem[txq_rd_ptr];
                txq_rd_ptr      <= txq_rd_ptr + ID_W'(1);
            end

            case ({wr_done, rd_start})
                2'b10:   txq_cnt <= txq_cnt + CNT_W'(1);
                2'b01:   txq_cnt <= txq_cnt - CNT_W'(1);
                default: txq_cnt <= txq_cnt;
            endcase

            if (rel_buf)
                gap_cnt <= GAP_LOAD;
            else if (r_state == R_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_done) txq_mem[txq_wr_ptr] <= cur_wid;
    end

    assign out_free_cnt = free_cnt;
    assign out_txq_cnt  = txq_cnt;

endmodule

// File: tb/tb_buf_addr_mgmt.sv
`timescale 1ns/1ps
// Bench for buf_addr_mgmt: free-list / TX-queue model feeding expected-address
// queues, a packet-length vector table, and directed multi-cycle sequences.
module tb_buf_addr_mgmt;

    localparam int BUF_NUM   = 16;
    localparam int BUF_SHIFT = 7;
    localparam int ADDR_W    = 11;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_pkt_req = 1'b0;
    logic [133:0]       in_data_ctrl_data = '0;
    logic               in_data_ctrl_data_wr = 1'b0;
    logic               in_ebm_ready = 1'b0;
    logic               out_data_cache_valid_wr = 1'b0;
    logic [ADDR_W-1:0]  addr2data_waddr;
    logic               addr2data_waddr_wr;
    logic [ADDR_W-1:0]  addr2data_raddr;
    logic               addr2data_raddr_wr;
    logic [4:0]         out_free_cnt;
    logic [4:0]         out_txq_cnt;
    logic               out_wr_err;

    buf_addr_mgmt #(.BUF_NUM(BUF_NUM), .BUF_SHIFT(BUF_SHIFT), .ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_pkt_req              (in_pkt_req),
        .in_data_ctrl_data       (in_data_ctrl_data),
        .in_data_ctrl_data_wr    (in_data_ctrl_data_wr),
        .in_ebm_ready            (in_ebm_ready),
        .out_data_cache_valid_wr (out_data_cache_valid_wr),
        .addr2data_waddr         (addr2data_waddr),
        .addr2data_waddr_wr      (addr2data_waddr_wr),
        .addr2data_raddr         (addr2data_raddr),
        .addr2data_raddr_wr      (addr2data_raddr_wr),
        .out_free_cnt            (out_free_cnt),
        .out_txq_cnt             (out_txq_cnt),
        .out_wr_err              (out_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nwords;
        int exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int n_grants = 0;
    int n_reads = 0;
    int err_cnt = 0;
    int exp_grants = 0;
    int exp_reads = 0;
    int last_rid = 0;
    int free_q[$];
    int txq_q[$];
    logic [ADDR_W-1:0] exp_w[$];
    logic [ADDR_W-1:0] exp_r[$];

    // Event counters only; all comparisons happen in the stimulus thread.
    always @(negedge clk) begin
        if (rst_n) begin
            if (addr2data_waddr_wr) n_grants <= n_grants + 1;
            if (addr2data_raddr_wr) n_reads <= n_reads + 1;
            if (out_wr_err) err_cnt <= err_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_waddr"}, addr2data_waddr, 0);
        check({nm, "_waddr_wr"}, addr2data_waddr_wr, 0);
        check({nm, "_raddr"}, addr2data_raddr, 0);
        check({nm, "_raddr_wr"}, addr2data_raddr_wr, 0);
        check({nm, "_free_cnt"}, out_free_cnt, BUF_NUM);
        check({nm, "_txq_cnt"}, out_txq_cnt, 0);
        check({nm, "_wr_err"}, out_wr_err, 0);
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        in_pkt_req = 1'b0;
        in_data_ctrl_data_wr = 1'b0;
        in_ebm_ready = 1'b0;
        out_data_cache_valid_wr = 1'b0;
        #1;
        check_reset(nm);
        repeat (3) @(negedge clk);
        free_q.delete();
        for (int i = 0; i < BUF_NUM; i++) free_q.push_back(i);
        txq_q.delete();
        exp_w.delete();
        exp_r.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_word(input bit tail);
        logic [133:0] w;
        w = '0;
        w[31:0]   = $urandom;
        w[63:32]  = $urandom;
        w[133:132] = tail ? 2'b10 : 2'b00;
        in_data_ctrl_data = w;
        in_data_ctrl_data_wr = 1'b1;
    endtask

    // Request a buffer, optionally releasing the buffer under read in the same
    // edge, then write an n-word packet ending in a tail word.
    task automatic send_pkt(input int n, input bit rel, output int lat);
        int id;
        bit got;
        id = free_q.pop_front();
        exp_w.push_back(ADDR_W'(id << BUF_SHIFT));
        exp_grants++;
        in_pkt_req = 1'b1;
        if (rel) begin
            out_data_cache_valid_wr = 1'b1;
            free_q.push_back(last_rid);
        end
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            out_data_cache_valid_wr = 1'b0;
            if (addr2data_waddr_wr) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        in_pkt_req = 1'b0;
        check("grant_seen", got, 1);
        if (!got) return;
        check("waddr", addr2data_waddr, exp_w.pop_front());
        for (int i = 0; i < n; i++) begin
            drive_word(i == n - 1);
            @(negedge clk);
        end
        in_data_ctrl_data_wr = 1'b0;
        txq_q.push_back(id);
    endtask

    task automatic start_read();
        bit got;
        last_rid = txq_q.pop_front();
        exp_r.push_back(ADDR_W'(last_rid << BUF_SHIFT));
        exp_reads++;
        in_ebm_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (addr2data_raddr_wr) begin
                got = 1'b1;
                break;
            end
        end
        in_ebm_ready = 1'b0;
        check("raddr_seen", got, 1);
        if (got) check("raddr", addr2data_raddr, exp_r.pop_front());
    endtask

    task automatic release_buf();
        out_data_cache_valid_wr = 1'b1;
        @(negedge clk);
        out_data_cache_valid_wr = 1'b0;
        free_q.push_back(last_rid);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int e0;
        int g0;
        int id;

        vecs[0] = '{1,   0};
        vecs[1] = '{2,   0};
        vecs[2] = '{4,   0};
        vecs[3] = '{127, 0};
        vecs[4] = '{128, 0};
        vecs[5] = '{129, 1};
        vecs[6] = '{130, 1};
        vecs[7] = '{200, 1};

        #2;
        do_reset("rst0");

        // Single 4-word packet with egress ready throughout.
        in_ebm_ready = 1'b1;
        send_pkt(4, 0, lat);
        check("t1_grant_lat", lat, 1);
        check("t1_txq_after_tail", out_txq_cnt, 1);
        id = txq_q.pop_front();
        last_rid = id;
        exp_reads++;
        check("t1_rd_not_early", addr2data_raddr_wr, 0);
        @(negedge clk);
        in_ebm_ready = 1'b0;
        check("t1_rd_pulse", addr2data_raddr_wr, 1);
        check("t1_raddr", addr2data_raddr, ADDR_W'(id << BUF_SHIFT));
        check("t1_free_in_use", out_free_cnt, BUF_NUM - 1);
        repeat (2) @(negedge clk);
        release_buf();
        check("t1_free_back", out_free_cnt, BUF_NUM);

        // Packet-length table: overrun flags exactly once, packet still queues.
        for (int v = 0; v < 8; v++) begin
            e0 = err_cnt;
            send_pkt(vecs[v].nwords, 0, lat);
            @(negedge clk);
            check($sformatf("vec%0d_len%0d_err", v, vecs[v].nwords), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("vec%0d_len%0d_txq", v, vecs[v].nwords), out_txq_cnt, 1);
            start_read();
            release_buf();
            check($sformatf("vec%0d_free", v), out_free_cnt, BUF_NUM);
        end

        // Sixteen back-to-back packets with egress stalled.
        do_reset("rst1");
        for (int i = 0; i < BUF_NUM; i++) send_pkt(3, 0, lat);
        check("fill_free_cnt", out_free_cnt, 0);
        check("fill_txq_cnt", out_txq_cnt, BUF_NUM);
        g0 = n_grants;
        in_pkt_req = 1'b1;
        repeat (10) @(negedge clk);
        in_pkt_req = 1'b0;
        check("no_grant_when_empty", n_grants - g0, 0);
        for (int i = 0; i < BUF_NUM; i++) begin
            start_read();
            release_buf();
        end
        check("drain_free_cnt", out_free_cnt, BUF_NUM);
        check("drain_txq_cnt", out_txq_cnt, 0);

        // Release and grant on the same edge; recycled id returns after a full wrap.
        do_reset("rst2");
        send_pkt(2, 0, lat);
        start_read();
        send_pkt(2, 1, lat);
        check("simul_free_hold", out_free_cnt, BUF_NUM - 1);
        for (int i = 0; i < BUF_NUM - 1; i++) send_pkt(2, 0, lat);
        check("wrap_reuse_addr", addr2data_waddr, 0);
        check("wrap_free_cnt", out_free_cnt, 0);
        check("wrap_txq_cnt", out_txq_cnt, BUF_NUM);
        for (int i = 0; i < BUF_NUM; i++) begin
            start_read();
            release_buf();
        end
        check("wrap_drain_free", out_free_cnt, BUF_NUM);

        // Data word with no grant outstanding.
        e0 = err_cnt;
        drive_word(1'b1);
        @(negedge clk);
        in_data_ctrl_data_wr = 1'b0;
        @(negedge clk);
        check("stray_word_err", err_cnt - e0, 1);
        check("stray_word_txq", out_txq_cnt, 0);
        send_pkt(2, 0, lat);
        check("after_stray_txq", out_txq_cnt, 1);

        // Reset while one packet is being read and another is being written.
        do_reset("rst3");
        send_pkt(2, 0, lat);
        start_read();
        release_buf();
        send_pkt(2, 0, lat);
        start_read();
        id = free_q.pop_front();
        exp_grants++;
        in_pkt_req = 1'b1;
        @(negedge clk);
        in_pkt_req = 1'b0;
        check("mid_grant_pulse", addr2data_waddr_wr, 1);
        check("mid_grant_addr", addr2data_waddr, ADDR_W'(id << BUF_SHIFT));
        drive_word(1'b0);
        repeat (2) @(negedge clk);
        in_data_ctrl_data_wr = 1'b0;
        do_reset("mid_rst");
        send_pkt(3, 0, lat);
        check("post_rst_waddr", addr2data_waddr, 0);
        check("post_rst_txq", out_txq_cnt, 1);

        repeat (3) @(negedge clk);
        check("grant_count", n_grants, exp_grants);
        check("read_count", n_reads, exp_reads);
        check("waddr_queue_left", exp_w.size(), 0);
        check("raddr_queue_left", exp_r.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
